// File: rtl/jk_pkg.sv
// jk_pkg: shared command and FSM state types for the JK bank arbiter
package jk_pkg;
  typedef enum logic [1:0] {JK_HOLD = 2'b00, JK_RST = 2'b01, JK_SET = 2'b10, JK_TGL = 2'b11} jk_cmd_e;
  typedef enum logic {IDLE, APPLY} fsm_e;
endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop with enable; clk, rst (async active-low), en, j, k -> q, q_bar
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else if (en) q <= (j & ~q) | (~k & q);
  assign q_bar = ~q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter applying {j,k} commands CNT+1 times to a JK bank
//   in : clk, rst (async active-low), req_valid/req_jk/req_idx/req_cnt per requester
//   out: req_ready (one-hot), q/q_bar bank state, busy, done pulse with done_id/done_err
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_jk,
  input  logic [IDXW*NREQ-1:0]     req_idx,
  input  logic [CNTW*NREQ-1:0]     req_cnt,
  output logic [NBITS-1:0]         q,
  output logic [NBITS-1:0]         q_bar,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     done_err
);
  localparam int IDW = $clog2(NREQ);
  fsm_e state, nstate;
  logic [IDW-1:0]   rr_ptr, win, id_l;
  logic [1:0]       jk_l;
  logic [IDXW-1:0]  idx_l;
  logic [CNTW-1:0]  cnt_l;
  logic             acc, last;
  logic [NBITS-1:0] en;
  // Scan downward so the valid requester closest to rr_ptr is the last write and wins.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int c;
      c = (int'(rr_ptr) + i) % NREQ;
      if (req_valid[c]) win = IDW'(c);
    end
  end
  assign req_ready = (state == IDLE && |req_valid) ? NREQ'(1) << win : '0;
  assign acc       = |(req_valid & req_ready);
  assign last      = state == APPLY && cnt_l == '0;
  assign busy      = state == APPLY;
  always_comb nstate = state == IDLE ? (acc ? APPLY : IDLE) : (last ? IDLE : APPLY);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr   <= '0;
      id_l     <= '0;
      jk_l     <= '0;
      idx_l    <= '0;
      cnt_l    <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      done_err <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        done_id  <= id_l;
        done_err <= int'(idx_l) >= NBITS;
      end
      if (acc) begin
        id_l   <= win;
        jk_l   <= req_jk[2*win +: 2];
        idx_l  <= req_idx[IDXW*win +: IDXW];
        cnt_l  <= req_cnt[CNTW*win +: CNTW];
        rr_ptr <= int'(win) == NREQ - 1 ? '0 : win + 1'b1;
      end else if (state == APPLY && !last) cnt_l <= cnt_l - 1'b1;
    end
  for (genvar b = 0; b < NBITS; b++) begin : g_bank
    assign en[b] = state == APPLY && int'(idx_l) == b;
    jk_cell u_cell (.clk(clk), .rst(rst), .en(en[b]), .j(jk_l[1]), .k(jk_l[0]), .q(q[b]), .q_bar(q_bar[b]));
  end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed self-checking bench for jk_bank_arbiter (NBITS=6 to reach bad indices)
module tb_jk_bank_arbiter;
  localparam int NREQ = 4, NBITS = 6, IDXW = 3, CNTW = 4;
  logic clk, rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [2*NREQ-1:0] req_jk;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [CNTW*NREQ-1:0] req_cnt;
  logic [NBITS-1:0] q, q_bar;
  logic busy, done, done_err, seen;
  logic [$clog2(NREQ)-1:0] done_id;
  int n_cmp, n_bad;
  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_jk(req_jk),
    .req_idx(req_idx), .req_cnt(req_cnt), .q(q), .q_bar(q_bar), .busy(busy), .done(done),
    .done_id(done_id), .done_err(done_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic v, input logic [1:0] jk, input int idx, input int cnt);
    req_valid[i] = v;
    req_jk[2*i +: 2] = jk;
    req_idx[IDXW*i +: IDXW] = IDXW'(idx);
    req_cnt[CNTW*i +: CNTW] = CNTW'(cnt);
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; seen = 0;
    clk = 0; rst = 0; req_valid = '0; req_jk = '0; req_idx = '0; req_cnt = '0;
    repeat (3) step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qbar", 32'(q_bar), 32'h3F);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1;
    repeat (2) step();
    chk("idle_q", 32'(q), 32'h00);
    chk("idle_qbar", 32'(q_bar), 32'h3F);
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    set_req(0, 1, 2'b10, 3, 0);
    #1 chk("set_ready", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 0;
    chk("set_busy", 32'(busy), 32'h1);
    chk("set_ready_apply", 32'(req_ready), 32'h0);
    step();
    chk("set_q", 32'(q), 32'h08);
    chk("set_done", 32'(done), 32'h1);
    chk("set_id", 32'(done_id), 32'h0);
    chk("set_err", 32'(done_err), 32'h0);
    chk("set_busy_end", 32'(busy), 32'h0);
    step();
    chk("done_pulse", 32'(done), 32'h0);
    set_req(1, 1, 2'b11, 0, 2);
    #1 chk("tgl_ready", 32'(req_ready), 32'h2);
    step();
    req_valid[1] = 0;
    chk("tgl_busy0", 32'(busy), 32'h1);
    step();
    chk("tgl_q1", 32'(q), 32'h09);
    chk("tgl_busy1", 32'(busy), 32'h1);
    step();
    chk("tgl_q2", 32'(q), 32'h08);
    chk("tgl_busy2", 32'(busy), 32'h1);
    step();
    chk("tgl_q3", 32'(q), 32'h09);
    chk("tgl_done", 32'(done), 32'h1);
    chk("tgl_id", 32'(done_id), 32'h1);
    chk("tgl_busy3", 32'(busy), 32'h0);
    rst = 0;
    step();
    rst = 1;
    step();
    chk("rr_rst_q", 32'(q), 32'h00);
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 2'b10, i, 0);
    #1;
    for (int g = 0; g < NREQ; g++) begin
      chk($sformatf("rr_ready%0d", g), 32'(req_ready), 32'(1) << g);
      step();
      req_valid[g] = 0;
      step();
      chk($sformatf("rr_done%0d", g), 32'(done), 32'h1);
      chk($sformatf("rr_id%0d", g), 32'(done_id), 32'(g));
    end
    chk("rr_q", 32'(q), 32'h0F);
    req_valid = 4'b1001;
    #1 chk("rr_wrap", 32'(req_ready), 32'h1);
    req_valid = '0;
    #1 chk("drop_ready", 32'(req_ready), 32'h0);
    step();
    chk("drop_busy", 32'(busy), 32'h0);
    set_req(2, 1, 2'b10, 7, 0);
    #1 chk("bad_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    chk("bad_done", 32'(done), 32'h1);
    chk("bad_err", 32'(done_err), 32'h1);
    chk("bad_id", 32'(done_id), 32'h2);
    chk("bad_q", 32'(q), 32'h0F);
    set_req(0, 1, 2'b01, 0, 15);
    #1 chk("abort_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    repeat (4) step();
    chk("abort_q4", 32'(q), 32'h0E);
    chk("abort_busy4", 32'(busy), 32'h1);
    @(posedge clk);
    rst = 0;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (2) step();
    rst = 1;
    repeat (20) begin
      step();
      if (done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    set_req(1, 1, 2'b10, 5, 1);
    #1 chk("post_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    chk("post_busy", 32'(busy), 32'h1);
    step();
    chk("post_done", 32'(done), 32'h1);
    chk("post_id", 32'(done_id), 32'h1);
    chk("post_q", 32'(q), 32'h20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
